multiword_add_sequencer: RTL

Word-serial multi-precision add/subtract controller that streams operands through the 16-bit carry-select adder one word per cycle. It holds the inter-word carry in a register and frames each operation with a start pulse and a last-word flag. Operands arrive least-significant word first from an upstream source, and results leave through a valid/ready stream. It sits directly upstream of `carry_select_adder_4x4`, which it instantiates, and is the sequential front-end for wide arithmetic built from 16-bit adder slices.

---
 rtl/multiword_add_sequencer_pkg.sv | 13 +
 rtl/carry_select_adder_4x4.sv | 25 ++
 rtl/multiword_add_sequencer.sv | 93 +++++++++
 3 files changed

// File: rtl/multiword_add_sequencer_pkg.sv
// Shared types and sizes for the word-serial multi-precision add/subtract sequencer.
package multiword_add_sequencer_pkg;

  localparam int WORD_W = 16;
  localparam int CNT_W  = $clog2(16) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/carry_select_adder_4x4.sv
// 16-bit adder built from four 4-bit carry-select blocks; each block precomputes
// both carry-in outcomes and the incoming carry picks one.
module carry_select_adder_4x4 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] s,
  output logic        c_out
);

  logic [4:0] c;

  assign c[0] = c_in;

  for (genvar g = 0; g < 4; g++) begin : g_blk
    logic [4:0] r0, r1;
    assign r0 = {1'b0, a[4*g +: 4]} + {1'b0, b[4*g +: 4]};
    assign r1 = r0 + 5'd1;
    assign s[4*g +: 4] = c[g] ? r1[3:0] : r0[3:0];
    assign c[g+1]      = c[g] ? r1[4]   : r0[4];
  end

  assign c_out = c[4];

endmodule

// File: rtl/multiword_add_sequencer.sv
// Streams WORDS 16-bit operand words (LS first) through one adder slice, carrying
// between words in a register, and emits results over a valid/ready stream.
module multiword_add_sequencer
  import multiword_add_sequencer_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sub,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] a_word,
  input  logic [WORD_W-1:0] b_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] s_word,
  output logic              out_last,
  output logic              c_out,
  output logic              ovf,
  output logic              busy
);

  state_t             state;
  logic               mode, cy;
  logic [CNT_W-1:0]   cnt;
  logic [WORD_W-1:0]  b_x, sum;
  logic               c_nxt, accept, consume, last_word;

  // Subtract is A + ~B + 1: the +1 comes from seeding cy with the mode bit.
  assign b_x       = b_word ^ {WORD_W{mode}};
  assign in_ready  = (state == RUN) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;
  assign last_word = (cnt == CNT_W'(WORDS - 1));
  assign busy      = (state != IDLE);

  carry_select_adder_4x4 u_add (
    .a     (a_word),
    .b     (b_x),
    .c_in  (cy),
    .s     (sum),
    .c_out (c_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mode      <= 1'b0;
      cy        <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      s_word    <= '0;
      out_last  <= 1'b0;
      c_out     <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (consume && !accept) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mode  <= sub;
            cy    <= sub;
            cnt   <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            cy        <= c_nxt;
            s_word    <= sum;
            out_valid <= 1'b1;
            out_last  <= last_word;
            cnt       <= cnt + CNT_W'(1);
            if (last_word) begin
              c_out <= c_nxt;
              ovf   <= (a_word[WORD_W-1] == b_x[WORD_W-1]) && (sum[WORD_W-1] != a_word[WORD_W-1]);
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (consume && out_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
